// File: rtl/pipe_reg_skid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg_skid_pkg
//  Description : Shared pipe-register definitions. Holds the occupancy state
//                encoding (EMPTY / ONE / TWO) used by elastic pipeline
//                registers; the encoding doubles as the occupancy count.
//  Contents    : state_t   - 2-bit state / occupancy encoding
//                c_OCC_W   - width of the occupancy count
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_reg_skid_pkg;

  localparam int c_OCC_W = 2;

  // Encoding equals the number of buffered entries, so count_o is the state.
  typedef enum logic [c_OCC_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage : pipe_reg_skid_pkg
`default_nettype wire

// File: rtl/pipe_reg_skid_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at its all-ones value. Reusable for
//                performance / stall statistics.
//  Ports       : clk_i  in   clock
//                rst_i  in   synchronous active-low reset (clears to 0)
//                inc    in   increment request
//                value  out  current count (CNT_W bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != c_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_reg_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg_skid
//  Description : Elastic pipeline register with valid/ready handshake, a
//                one-entry skid buffer, synchronous flush and a saturating
//                stall counter. Both handshake outputs are registered, so
//                there is no combinational path from out_ready_i to
//                in_ready_o nor from in_valid_i to out_valid_o.
//  Ports       : clk_i        in   clock
//                rst_i        in   synchronous active-low reset
//                flush_i      in   discard all buffered entries
//                in_valid_i   in   upstream payload valid
//                in_ready_o   out  block can accept (registered)
//                in_data_i    in   upstream payload
//                out_valid_o  out  out_data_o valid (registered)
//                out_ready_i  in   downstream accepts
//                out_data_o   out  payload to downstream (registered)
//                count_o      out  occupancy 0..2
//                stall_cnt_o  out  saturating count of stalled cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_skid
  import pipe_reg_skid_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE  = '0,
  parameter bit               FLUSH_ZERO = 1'b1,
  parameter int               CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       count_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q,  main_d;
  logic [WIDTH-1:0] skid_q,  skid_d;
  logic             in_ready_q;
  logic             out_valid_q;

  logic w_accept;
  logic w_pop;

  assign w_accept = in_valid_i  & in_ready_q;
  assign w_pop    = out_valid_q & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (w_accept) begin
          state_d = ST_ONE;
          main_d  = in_data_i;
        end
      end
      ST_ONE: begin
        if (w_accept && w_pop) begin
          main_d = in_data_i;
        end else if (w_accept) begin
          // Downstream stalled: park the word that was already in flight.
          state_d = ST_TWO;
          skid_d  = in_data_i;
        end else if (w_pop) begin
          // main_q keeps its last value while out_valid_o drops.
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready_o is low here, so only a pop can happen.
        if (w_pop) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush wins over any same-cycle accept or pop; the accepted word
    // belongs to an upstream stage that is being flushed too.
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = FLUSH_ZERO ? NOP_VALUE : main_q;
    end
  end

  // Handshake flags are derived from the next state so they are registered
  // outputs yet exact for the following cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_EMPTY;
      main_q      <= NOP_VALUE;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (in_valid_i & ~in_ready_q),
    .value (stall_cnt_o)
  );

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;
  assign count_o     = state_q;

endmodule : pipe_reg_skid
`default_nettype wire

// File: tb/tb_pipe_reg_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_reg_skid
//  Description : Self-checking bench for pipe_reg_skid. Two instances share
//                stimulus: dut_a (FLUSH_ZERO=1, CNT_W=8) and dut_b
//                (FLUSH_ZERO=0, CNT_W=2). A queue-based reference model
//                predicts occupancy, data and stall counts each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_reg_skid;

  localparam int         W   = 8;
  localparam logic [7:0] NOP = 8'hEE;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [W-1:0] a_out_data, b_out_data;
  logic [1:0]   a_count, b_count;
  logic [7:0]   a_stall;
  logic [1:0]   b_stall;

  always #5 clk = ~clk;

  pipe_reg_skid #(.WIDTH(W), .NOP_VALUE(NOP), .FLUSH_ZERO(1'b1), .CNT_W(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_data_i(in_data),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_data_o(a_out_data),
    .count_o(a_count), .stall_cnt_o(a_stall)
  );

  pipe_reg_skid #(.WIDTH(W), .NOP_VALUE(NOP), .FLUSH_ZERO(1'b0), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_data_i(in_data),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_data_o(b_out_data),
    .count_o(b_count), .stall_cnt_o(b_stall)
  );

  // Reference model: FIFO contents, visible data per flush flavour, stalls.
  logic [W-1:0] q[$];
  logic [W-1:0] da = NOP;
  logic [W-1:0] db = NOP;
  int unsigned  sa = 0;
  int unsigned  sb = 0;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic fl, input logic v,
                      input logic [W-1:0] d, input logic rdy);
    bit full;
    bit acc;
    bit pop;
    @(negedge clk);
    rst = r; flush = fl; in_valid = v; in_data = d; out_ready = rdy;
    @(posedge clk);
    full = (q.size() == 2);
    acc  = v && !full;
    pop  = (q.size() > 0) && rdy;
    if (!r) begin
      q.delete();
      da = NOP; db = NOP; sa = 0; sb = 0;
    end else begin
      if (v && full) begin
        if (sa < 255) sa++;
        if (sb < 3)   sb++;
      end
      if (fl) begin
        q.delete();
        da = NOP;
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(d);
        if (q.size() > 0) begin
          da = q[0];
          db = q[0];
        end
      end
    end
    #1;
    chk("a_in_ready",  32'(a_in_ready),  32'(q.size() < 2));
    chk("a_out_valid", 32'(a_out_valid), 32'(q.size() > 0));
    chk("a_out_data",  32'(a_out_data),  32'(da));
    chk("a_count",     32'(a_count),     32'(q.size()));
    chk("a_stall",     32'(a_stall),     sa);
    chk("b_in_ready",  32'(b_in_ready),  32'(q.size() < 2));
    chk("b_out_valid", 32'(b_out_valid), 32'(q.size() > 0));
    chk("b_out_data",  32'(b_out_data),  32'(db));
    chk("b_count",     32'(b_count),     32'(q.size()));
    chk("b_stall",     32'(b_stall),     sb);
  endtask

  initial begin
    // Reset held two cycles with valid asserted.
    step(0, 0, 1, 8'h99, 0);
    step(0, 0, 1, 8'h99, 0);

    // Streaming at full rate.
    step(1, 0, 1, 8'h11, 1);
    step(1, 0, 1, 8'h22, 1);
    step(1, 0, 1, 8'h33, 1);
    step(1, 0, 0, 8'h00, 1);

    // Back-pressure: A1, A2 fill main+skid, A3 held upstream.
    step(1, 0, 1, 8'hA1, 0);
    step(1, 0, 1, 8'hA2, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 8'hA3, 0);
    step(1, 0, 1, 8'hA3, 1);
    step(1, 0, 1, 8'hA3, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, 1);

    // Flush while TWO with a word offered: BB must never appear.
    step(1, 0, 1, 8'hC1, 0);
    step(1, 0, 1, 8'hC2, 0);
    step(1, 1, 1, 8'hBB, 0);
    step(1, 0, 0, 8'h00, 1);
    step(1, 0, 0, 8'h00, 1);

    // Flush while holding 0x55: dut_b keeps 0x55, dut_a shows NOP.
    step(1, 0, 1, 8'h55, 0);
    step(1, 0, 0, 8'h00, 0);
    step(1, 1, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 1);

    // Saturation of the 2-bit stall counter, then a flush under stall.
    step(0, 0, 0, 8'h00, 0);
    step(1, 0, 1, 8'h01, 0);
    step(1, 0, 1, 8'h02, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 8'h03, 0);
    step(1, 1, 1, 8'h03, 0);
    step(1, 0, 0, 8'h00, 1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 500; i++) begin
      step(logic'($urandom_range(0, 59) != 0),
           logic'($urandom_range(0, 24) == 0),
           logic'($urandom_range(0, 3) != 0),
           W'($urandom),
           logic'($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_pipe_reg_skid
`default_nettype wire

// File: doc/pipe_reg_skid.md
# pipe_reg_skid

Parametrised elastic pipeline register with valid/ready handshake, a one-entry skid buffer, synchronous flush, and a saturating stall counter. Next-generation replacement for the fixed IF/ID-style hold/flush registers. It sits between any two CPU pipeline stages (IF/ID, ID/EX, ...). It decouples back-pressure so a stall no longer needs a combinational path back through the upstream stage.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- NOP_VALUE, 0, payload driven on out_data_o after reset or flush (WIDTH bits)
- FLUSH_ZERO, 1, 1: flush loads NOP_VALUE into out_data_o; 0: flush clears valid only, data holds
- CNT_W, 8, stall counter width (≥1)

- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-low reset
- flush_i  in  1  discard all buffered entries this cycle
- in_valid_i  in  1  upstream payload valid
- in_ready_o  out  1  block can accept; registered
- in_data_i  in  WIDTH  upstream payload
- out_valid_o  out  1  out_data_o valid; registered
- out_ready_i  in  1  downstream accepts
- out_data_o  out  WIDTH  payload to downstream; registered
- count_o  out  2  occupancy 0..2
- stall_cnt_o  out  CNT_W  cycles with in_valid_i=1 and in_ready_o=0, saturating

## Operation
- accept = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- Storage: main register (drives out_data_o), skid register (hidden).
- States: EMPTY (count 0), ONE (main valid), TWO (main and skid valid).
- EMPTY: accept → ONE, main ← in_data_i; else stay.
- ONE: accept&pop → ONE, main ← in_data_i. accept&!pop → TWO, skid ← in_data_i. !accept&pop → EMPTY. Otherwise stay.
- TWO: in_ready_o=0, so no accept. pop → ONE, main ← skid. Otherwise stay.
- in_ready_o = (next state != TWO); out_valid_o = (next state != EMPTY); both registered.
- EMPTY after a pop: out_data_o holds its last value and out_valid_o=0.
- Flush: next state EMPTY, in_ready_o←1, out_valid_o←0, skid discarded.
  - FLUSH_ZERO=1: out_data_o←NOP_VALUE.
  - Flush overrides any simultaneous accept or pop. The accepted input is dropped, because upstream is flushed in the same cycle.
- Stall counter: increments when in_valid_i & !in_ready_o, saturates at 2^CNT_W−1. Cleared only by reset; flush does not clear it.
- Reset (rst_i=0 at an edge):
  - state EMPTY, in_ready_o=1, out_valid_o=0, out_data_o=NOP_VALUE, count_o=0, stall_cnt_o=0.
  - Reset overrides flush and handshakes. Reset mid-transfer drops all contents.

## Timing
- Latency: accept in cycle n → out_valid_o=1 with that data in cycle n+1.
- Throughput 1 transfer/cycle while out_ready_i=1.
- Back-pressure: out_ready_i low at edge n → in_ready_o low no earlier than n+1. One extra word is absorbed in the skid.
- TWO with pop at edge n → in_ready_o=1 in n+1. A new accept is possible in n+1; no bubble is required.
- No combinational path from out_ready_i to in_ready_o, or from in_valid_i to out_valid_o.
- Ordering is strictly FIFO; no reordering or duplication.

## Structure
- Shared package/include (pipe_defs): state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2, reused by future pipe registers.
- count_o equals the state encoding; no separate counter.
- One natural sub-module: sat_counter (parameter CNT_W; inputs clk_i, rst_i, inc; output value), reusable for performance counters.

## Test plan
- Reset: hold rst_i=0 for 2 cycles with in_valid_i=1 → in_ready_o=1, out_valid_o=0, out_data_o=NOP_VALUE, count_o=0, stall_cnt_o=0.
- Streaming: out_ready_i=1, send 0x11,0x22,0x33 on consecutive cycles → out_data_o shows 0x11,0x22,0x33 one cycle later each, count_o stays 1.
- Back-pressure: stream 0xA1,0xA2,0xA3 with out_ready_i=0 from cycle 1.
  - Required: count_o=2 and in_ready_o=0 after 0xA2; 0xA3 held upstream and stall_cnt_o increments each held cycle.
  - Release out_ready_i → output order A1,A2,A3 with no loss.
- Flush in TWO: flush_i=1 with in_valid_i=1 (0xBB) → next cycle count_o=0, out_valid_o=0, out_data_o=NOP_VALUE (FLUSH_ZERO=1); 0xBB is never output.
- FLUSH_ZERO=0: flush while holding 0x55 → out_valid_o=0, out_data_o stays 0x55.
- Saturation: CNT_W=2, hold stall for 6 cycles → stall_cnt_o 1,2,3,3,3,3; a flush leaves it at 3.
